// File: rtl/pc_fetch_pkg.sv
// Shared types and default widths for the Hack program counter / fetch unit.
// Optional feature macro: PC_HALT_LOOP_EN (adds the terminal HALT state).
package pc_fetch_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;

    // Fetch sequencer states; HALT exists only when the self-loop halt is built in.
    typedef enum logic [2:0] {
        RST   = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3
`ifdef PC_HALT_LOOP_EN
        ,
        HALT  = 3'd4
`endif
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset, load has priority over inc,
// otherwise hold. Increment wraps modulo 2^ADDR_W.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] q_reg;

    // PC update: load wins over inc, natural wrap on increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end else if (inc) begin
            q_reg <= q_reg + ADDR_W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pc_fetch_unit.sv
// Hack CPU program counter plus instruction-fetch sequencer.
// ROM reads use a req/ack handshake (wait states tolerated); fetched
// instructions go to the execute stage over a valid/ready handshake.
// Optional feature macro: PC_HALT_LOOP_EN (halted port + HALT state on a
// retired self-jump).
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
`ifdef PC_HALT_LOOP_EN
    output logic              halted,
`endif
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state_reg, state_next;
    logic              rom_req_reg, rom_req_next;
    logic              instr_valid_reg, instr_valid_next;
    logic [DATA_W-1:0] instr_reg;
    logic              capture;
    logic              pc_ld;
    logic              pc_in;
    logic [ADDR_W-1:0] pc_q;

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_ld),
        .inc   (pc_in),
        .d     (jmp_addr),
        .q     (pc_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, data capture strobe and PC update controls.
    always_comb begin
        state_next       = state_reg;
        capture          = 1'b0;
        pc_ld            = 1'b0;
        pc_in            = 1'b0;
        case (state_reg)
            RST: begin
                state_next = REQ;
            end
            REQ, WAIT: begin
                // Ack in the REQ cycle itself skips WAIT entirely.
                if (rom_ack) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = WAIT;
                end
            end
            ISSUE: begin
                // Jump-control inputs are only meaningful while the execute
                // stage is retiring the instruction.
                if (instr_ready) begin
                    pc_ld      = pc_load;
                    pc_in      = !pc_load && pc_inc;
                    state_next = REQ;
`ifdef PC_HALT_LOOP_EN
                    if (pc_load && (jmp_addr == pc_q)) begin
                        state_next = HALT;
                    end
`endif
                end
            end
`ifdef PC_HALT_LOOP_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: begin
                state_next = RST;
            end
        endcase
        // Outputs are registered from the state being entered.
        rom_req_next     = (state_next == REQ) || (state_next == WAIT);
        instr_valid_next = (state_next == ISSUE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_req_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
        end else begin
            rom_req_reg     <= rom_req_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    // Instruction capture on ROM ack while a request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= '0;
        end else if (capture) begin
            instr_reg <= rom_data;
        end
    end

`ifdef PC_HALT_LOOP_EN
    logic halted_reg;

    // Sticky halt flag, set when the self-loop jump retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_reg <= 1'b0;
        end else if (state_next == HALT) begin
            halted_reg <= 1'b1;
        end
    end

    assign halted = halted_reg;
`endif

    // The PC only changes at retirement, so it is always the address of the
    // instruction in flight and doubles as the ROM address.
    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign rom_req     = rom_req_reg;
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Hack CPU program counter plus instruction-fetch sequencer. It consumes the jump-control outputs pc_load and pc_inc and updates the PC from them.
- Issues ROM read requests through a req/ack handshake, so wait-state ROM is tolerated.
- Presents each fetched instruction to the execute stage through a valid/ready handshake.
- Sits between the jump-control logic and the instruction ROM, and is the sole owner of the PC.

Parameters:
- ADDR_W, 15, PC/ROM address width (Hack 32K ROM).
- DATA_W, 16, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_load  in  1  from jump control: load PC with jump target.
- pc_inc  in  1  from jump control: advance PC by one.
- jmp_addr  in  ADDR_W  jump target (A register low bits).
- rom_req  out  1  ROM read request.
- rom_addr  out  ADDR_W  ROM read address.
- rom_ack  in  1  ROM data valid this cycle.
- rom_data  in  DATA_W  ROM read data.
- instr  out  DATA_W  instruction to execute stage.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  execute stage retires instr this cycle; pc_load/pc_inc are valid when this is high.
- pc  out  ADDR_W  current PC.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following hold within the reset and in the first cycle after release:
  - pc=0, rom_req=0, rom_addr=0, instr=0, instr_valid=0.
  - State is RST.
- FSM states: RST, REQ, WAIT, ISSUE.
- RST: go to REQ on the next clock; no outputs are asserted.
- REQ:
  - rom_req=1 and rom_addr=pc, registered.
  - If rom_ack is high in the same cycle, capture rom_data into instr and go to ISSUE. Otherwise go to WAIT.
- WAIT:
  - Hold rom_req=1 and rom_addr stable until rom_ack.
  - On rom_ack, capture instr and go to ISSUE.
  - rom_req drops the cycle after ack.
- ISSUE:
  - instr_valid=1; instr stays stable until retired.
  - On instr_ready=1, retire the instruction and update the PC:
    - pc_load=1: pc<=jmp_addr. pc_load wins if pc_inc is also 1.
    - else if pc_inc=1: pc<=pc+1, modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000.
    - else: pc holds and the same address is refetched.
  - After retirement: instr_valid<=0, next state REQ.
  - With instr_ready=0: stay in ISSUE and ignore pc_load/pc_inc.
- Minimum latency is 2 cycles from entering REQ to instr_valid (zero-wait ROM). Throughput is one instruction per 2 cycles with zero-wait ROM.
- pc changes only at retirement. The pc output equals the address of the instruction currently in WAIT/ISSUE.
- A rom_ack arriving outside REQ/WAIT is ignored.
- rst_n asserted mid-transfer (WAIT or ISSUE): immediate return to reset values; the pending ROM transaction is abandoned.

Optional Feature:
- Macro: PC_HALT_LOOP_EN.
- When defined:
  - Adds output port halted (1 bit, reset 0).
  - At retirement with pc_load=1 and jmp_addr==pc (the Hack end-of-program "@END; 0;JMP" self-loop, same address), halted<=1 and the FSM enters terminal state HALT.
  - In HALT: no further rom_req, instr_valid=0, pc frozen. Only reset exits HALT.
- When undefined:
  - No halted port and no HALT state.
  - A self-jump refetches forever per the normal rules.

Decomposition:
- Package pc_fetch_pkg holds:
  - fetch_state_t enum {RST, REQ, WAIT, ISSUE, HALT}. HALT is present only under PC_HALT_LOOP_EN.
  - localparam defaults HACK_ADDR_W=15 and HACK_DATA_W=16.
- Sub-module pc_reg holds the ADDR_W-bit register with async reset, load (priority), inc and hold. pc_fetch_unit contains the FSM and handshake logic.

Test Plan:
- Zero-wait ROM (ack in the REQ cycle), instr_ready=1, pc_inc=1: after reset, rom_addr sequence is 0,1,2,3, with instr_valid high every 2nd cycle.
- ROM with 3 wait cycles: rom_req and rom_addr stay stable for 4 cycles; instr equals rom_data captured at ack; no duplicate instr_valid.
- In ISSUE at pc=5: drive pc_load=1, pc_inc=1, jmp_addr=0x0123 → next rom_addr=0x0123. Drive pc_load=0, pc_inc=0 at pc=0x0123 → refetch of 0x0123.
- instr_ready held 0 for 5 cycles while pc_inc=1: instr and pc stay stable and pc does not advance. When instr_ready pulses 1, pc advances exactly once.
- pc=0x7FFF, pc_inc=1 retire → next rom_addr=0x0000. rst_n low during WAIT at pc=0x0040 → rom_req=0, pc=0 immediately, and fetch restarts at 0.
- PC_HALT_LOOP_EN defined, at pc=0x0010 with pc_load=1 and jmp_addr=0x0010 retired → halted=1 and rom_req stays 0. With jmp_addr=0x0011 → no halt.
